ddr3_cal_ctrl: RTL

DDR3_CAL_CTRL -- requirements
Module: ddr3_cal_ctrl

---
 rtl/ddr3_cal_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ddr3_cal_ctrl.sv
// DDR3 read-leveling calibration sequencer: writes a pattern once, then issues
// reads until the PHY reports calibration, retries run out, or a read burst times out.
// Status and command outputs are registered from the next-state decode; commands wait for cmd_ack_i.
module ddr3_cal_ctrl #(
   parameter int unsigned CAL_TRIES = 8,   // read attempts before giving up (1..15)
   parameter int unsigned TIMEOUT   = 63,  // cycles allowed in RWAIT for a full burst
   parameter int unsigned RD_GAP    = 4    // idle cycles between commands (>=1)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_i,
   output logic       cmd_req_o,
   output logic       cmd_rd_o,
   input  logic       cmd_ack_i,
   output logic       dfi_align_o,
   input  logic       dfi_rvld_i,
   input  logic       dfi_calib_i,
   input  logic [2:0] dfi_shift_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       fail_o,
   output logic [2:0] shift_o,
   output logic [3:0] tries_o
);

   localparam int unsigned GAP_W = (RD_GAP < 2) ? 1 : $clog2(RD_GAP + 1);

   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(RD_GAP);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
   localparam logic [5:0]       TO_LAST   = 6'(TIMEOUT - 1);
   localparam logic [3:0]       TRIES_MAX = 4'(CAL_TRIES);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_WRITE = 4'd1,
      S_WGAP  = 4'd2,
      S_READ  = 4'd3,
      S_RWAIT = 4'd4,
      S_CHECK = 4'd5,
      S_RGAP  = 4'd6,
      S_DONE  = 4'd7,
      S_FAIL  = 4'd8
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [GAP_W-1:0] r_gap_cnt;
   logic [5:0]       r_to_cnt;
   logic             r_rvld_q;
   logic [3:0]       r_tries;
   logic [2:0]       r_shift;

   logic             r_req;
   logic             r_rd;
   logic             r_align;
   logic             r_busy;
   logic             r_done;
   logic             r_fail;

   logic             w_req;
   logic             w_rd;
   logic             w_align;
   logic             w_busy;
   logic             w_done;
   logic             w_fail;

   logic             w_idle_like;
   logic             w_start_acc;
   logic             w_burst_done;
   logic             w_gap_entry;
   logic             w_rwait_entry;
   logic             w_read_xfer;

   // Event decode shared by the FSM and the datapath registers.
   assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL);
   assign w_start_acc   = w_idle_like && start_i;
   // Burst end is the falling edge of read-valid, seen only while waiting for data.
   assign w_burst_done  = (r_state == S_RWAIT) && r_rvld_q && !dfi_rvld_i;
   assign w_gap_entry   = ((w_next == S_WGAP) && (r_state != S_WGAP)) ||
                          ((w_next == S_RGAP) && (r_state != S_RGAP));
   assign w_rwait_entry = (w_next == S_RWAIT) && (r_state != S_RWAIT);
   assign w_read_xfer   = (r_state == S_READ) && cmd_ack_i;

   // Next-state and next-output decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start_i) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (cmd_ack_i) w_next = S_WGAP;
         end
         S_WGAP, S_RGAP: begin
            if (r_gap_cnt == GAP_ONE) w_next = S_READ;
         end
         S_READ: begin
            if (cmd_ack_i) w_next = S_RWAIT;
         end
         S_RWAIT: begin
            // A burst finishing on the last allowed cycle still counts.
            if (w_burst_done)            w_next = S_CHECK;
            else if (r_to_cnt == TO_LAST) w_next = S_FAIL;
         end
         S_CHECK: begin
            if (dfi_calib_i)               w_next = S_DONE;
            else if (r_tries == TRIES_MAX) w_next = S_FAIL;
            else                           w_next = S_RGAP;
         end
         default: w_next = S_IDLE;
      endcase

      w_req   = (w_next == S_WRITE) || (w_next == S_READ);
      w_rd    = (w_next == S_READ);
      w_align = (w_next == S_READ) || (w_next == S_RWAIT) ||
                (w_next == S_CHECK) || (w_next == S_RGAP);
      w_busy  = !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_FAIL));
      w_done  = (w_next == S_DONE);
      w_fail  = (w_next == S_FAIL);
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Registered outputs, aligned with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_req   <= 1'b0;
         r_rd    <= 1'b0;
         r_align <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_fail  <= 1'b0;
      end else begin
         r_req   <= w_req;
         r_rd    <= w_rd;
         r_align <= w_align;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_fail  <= w_fail;
      end
   end

   // Gap counter: loaded on WGAP/RGAP entry, counts down to the READ issue.
   always_ff @(posedge clock) begin
      if (reset)                                            r_gap_cnt <= '0;
      else if (w_gap_entry)                                 r_gap_cnt <= GAP_LOAD;
      else if ((r_state == S_WGAP) || (r_state == S_RGAP))  r_gap_cnt <= r_gap_cnt - GAP_ONE;
   end

   // Read-data timeout counter: zero on RWAIT entry, one step per waiting cycle.
   always_ff @(posedge clock) begin
      if (reset)                   r_to_cnt <= '0;
      else if (w_rwait_entry)      r_to_cnt <= '0;
      else if (r_state == S_RWAIT) r_to_cnt <= r_to_cnt + 6'd1;
   end

   // Read-valid history; held clear outside RWAIT so stray pulses never complete a burst.
   always_ff @(posedge clock) begin
      if (reset) r_rvld_q <= 1'b0;
      else       r_rvld_q <= (r_state == S_RWAIT) && dfi_rvld_i;
   end

   // Read-attempt count: cleared when a run starts, bumped on each READ handshake.
   always_ff @(posedge clock) begin
      if (reset)            r_tries <= '0;
      else if (w_start_acc) r_tries <= '0;
      else if (w_read_xfer) r_tries <= r_tries + 4'd1;
   end

   // Capture the PHY shift at the moment calibration is confirmed; kept across runs.
   always_ff @(posedge clock) begin
      if (reset)                                  r_shift <= '0;
      else if ((r_state == S_CHECK) && dfi_calib_i) r_shift <= dfi_shift_i;
   end

   assign cmd_req_o   = r_req;
   assign cmd_rd_o    = r_rd;
   assign dfi_align_o = r_align;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign fail_o      = r_fail;
   assign shift_o     = r_shift;
   assign tries_o     = r_tries;

endmodule
